// File: rtl/fsmc_avm_bridge.sv
// FSMC host port to Avalon-MM master bridge with a posted-write FIFO,
// read-after-write ordering and a per-transfer bus timeout with sticky error.
module fsmc_avm_bridge #(
  parameter int AW          = 32,
  parameter int DW          = 16,
  parameter int WFIFO_DEPTH = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic                           avm_clk,
  input  logic                           avm_reset_n,
  input  logic [AW-1:0]                  addr,
  input  logic                           ncs,
  input  logic                           rd_start,
  input  logic                           wr_start,
  input  logic [DW/8-1:0]                byte_en,
  input  logic [DW-1:0]                  data_in,
  output logic [DW-1:0]                  data_out,
  output logic                           wait_out,
  output logic                           err,
  input  logic                           err_clr,
  output logic [$clog2(WFIFO_DEPTH):0]   wfifo_level,
  output logic [AW-1:0]                  avm_addr,
  output logic                           avm_rd,
  output logic                           avm_wr,
  output logic [DW-1:0]                  avm_wdata,
  output logic [DW/8-1:0]                avm_byte_en,
  input  logic [DW-1:0]                  avm_rdata,
  input  logic                           avm_rdvalid,
  input  logic                           avm_wait
);

  localparam int BEW = DW / 8;
  localparam int PW  = $clog2(WFIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam int EW  = AW + DW + BEW;
  localparam int TCW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TCW-1:0] T_LAST   = (TIMEOUT > 0) ? TCW'(TIMEOUT - 1) : '0;
  localparam logic [CW-1:0]  FULL_CNT = CW'(WFIFO_DEPTH);

  typedef enum logic [1:0] {H_IDLE, H_WFULL, H_READ} h_state_t;
  typedef enum logic [2:0] {M_IDLE, M_WRITE, M_DRAIN, M_READ, M_READ_DATA} m_state_t;

  h_state_t h_state_reg, h_state_next;
  m_state_t m_state_reg, m_state_next;

  // ---------------------------------------------------------------- FIFO
  logic [EW-1:0] fifo_mem [WFIFO_DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          push, pop;
  logic [EW-1:0] push_entry, head_entry;

  assign head_entry = fifo_mem[rd_ptr_reg];

  always_ff @(posedge avm_clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= push_entry;
  end

  always_ff @(posedge avm_clk or negedge avm_reset_n) begin
    if (!avm_reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // ------------------------------------------------------- shared decode
  logic          rd_prev_reg, wr_prev_reg;
  logic          wr_edge, rd_edge, rd_take, rd_go, fifo_empty, space;
  logic          rd_pend_reg, read_done, wr_done, timeout_hit, in_xfer;
  logic [AW-1:0] rd_addr_reg, rd_addr_sel;
  logic [TCW-1:0] tcnt_reg;

  assign wr_edge     = wr_start & ~wr_prev_reg & ~ncs;
  assign rd_edge     = rd_start & ~rd_prev_reg & ~ncs;
  // A write edge in the same cycle wins; the read is dropped.
  assign rd_take     = (h_state_reg == H_IDLE) & rd_edge & ~wr_edge;
  assign rd_go       = rd_pend_reg | rd_take;
  assign rd_addr_sel = rd_take ? addr : rd_addr_reg;
  assign fifo_empty  = (count_reg == '0);
  assign space       = (count_reg != FULL_CNT) | pop;
  assign in_xfer     = m_state_reg inside {M_WRITE, M_READ, M_READ_DATA};
  assign timeout_hit = (TIMEOUT != 0) && in_xfer && (tcnt_reg == T_LAST);
  assign wr_done     = (m_state_reg == M_WRITE) && (!avm_wait || timeout_hit);

  // ------------------------------------------------------------ host FSM
  logic          wait_reg, wait_next, latch_pend;
  logic [EW-1:0] pend_entry_reg;

  always_ff @(posedge avm_clk or negedge avm_reset_n) begin
    if (!avm_reset_n) begin
      h_state_reg    <= H_IDLE;
      wait_reg       <= 1'b1;
      pend_entry_reg <= '0;
      rd_pend_reg    <= 1'b0;
      rd_addr_reg    <= '0;
      // Strobes held high across reset must not look like fresh requests.
      rd_prev_reg    <= 1'b1;
      wr_prev_reg    <= 1'b1;
    end else begin
      h_state_reg <= h_state_next;
      wait_reg    <= wait_next;
      rd_prev_reg <= rd_start;
      wr_prev_reg <= wr_start;
      if (latch_pend) pend_entry_reg <= {addr, data_in, byte_en};
      if (rd_take) begin
        rd_pend_reg <= 1'b1;
        rd_addr_reg <= addr;
      end else if (read_done) begin
        rd_pend_reg <= 1'b0;
      end
    end
  end

  always_comb begin
    h_state_next = h_state_reg;
    case (h_state_reg)
      H_IDLE: begin
        if (wr_edge && !space) h_state_next = H_WFULL;
        else if (rd_take)      h_state_next = H_READ;
      end
      H_WFULL: if (space)     h_state_next = H_IDLE;
      H_READ:  if (read_done) h_state_next = H_IDLE;
      default: h_state_next = H_IDLE;
    endcase
  end

  always_comb begin
    push       = 1'b0;
    push_entry = {addr, data_in, byte_en};
    wait_next  = wait_reg;
    latch_pend = 1'b0;
    case (h_state_reg)
      H_IDLE: begin
        if (wr_edge) begin
          if (space) begin
            push = 1'b1;
          end else begin
            latch_pend = 1'b1;
            wait_next  = 1'b0;
          end
        end else if (rd_take) begin
          wait_next = 1'b0;
        end
      end
      H_WFULL: begin
        push_entry = pend_entry_reg;
        if (space) begin
          push      = 1'b1;
          wait_next = 1'b1;
        end
      end
      H_READ:  if (read_done) wait_next = 1'b1;
      default: wait_next = 1'b1;
    endcase
  end

  // ---------------------------------------------------------- master FSM
  logic          avm_rd_reg, avm_rd_next, avm_wr_reg, avm_wr_next;
  logic [AW-1:0] avm_addr_reg, avm_addr_next;
  logic [DW-1:0] avm_wdata_reg, avm_wdata_next, data_out_reg, data_out_next;
  logic [BEW-1:0] avm_byte_en_reg, avm_byte_en_next;
  logic          err_reg, err_next, tcnt_clr;

  always_ff @(posedge avm_clk or negedge avm_reset_n) begin
    if (!avm_reset_n) begin
      m_state_reg     <= M_IDLE;
      avm_rd_reg      <= 1'b0;
      avm_wr_reg      <= 1'b0;
      avm_addr_reg    <= '0;
      avm_wdata_reg   <= '0;
      avm_byte_en_reg <= '0;
      data_out_reg    <= '0;
      err_reg         <= 1'b0;
      tcnt_reg        <= '0;
    end else begin
      m_state_reg     <= m_state_next;
      avm_rd_reg      <= avm_rd_next;
      avm_wr_reg      <= avm_wr_next;
      avm_addr_reg    <= avm_addr_next;
      avm_wdata_reg   <= avm_wdata_next;
      avm_byte_en_reg <= avm_byte_en_next;
      data_out_reg    <= data_out_next;
      err_reg         <= err_next;
      if (tcnt_clr)     tcnt_reg <= '0;
      else if (in_xfer) tcnt_reg <= tcnt_reg + 1'b1;
    end
  end

  // The in-flight write stays at the FIFO head until it completes, so a
  // read issues straight from M_WRITE when that head is the last entry.
  always_comb begin
    m_state_next = m_state_reg;
    case (m_state_reg)
      M_IDLE, M_DRAIN: begin
        if (!fifo_empty) m_state_next = M_WRITE;
        else if (rd_go)  m_state_next = M_READ;
        else             m_state_next = M_IDLE;
      end
      M_WRITE: begin
        if (wr_done) begin
          if (rd_go && count_reg == CW'(1)) m_state_next = M_READ;
          else if (rd_go)                   m_state_next = M_DRAIN;
          else                              m_state_next = M_IDLE;
        end
      end
      M_READ: begin
        if (timeout_hit)    m_state_next = M_IDLE;
        else if (!avm_wait) m_state_next = M_READ_DATA;
      end
      M_READ_DATA: if (timeout_hit || avm_rdvalid) m_state_next = M_IDLE;
      default: m_state_next = M_IDLE;
    endcase
  end

  always_comb begin
    pop              = 1'b0;
    read_done        = 1'b0;
    tcnt_clr         = 1'b0;
    avm_rd_next      = avm_rd_reg;
    avm_wr_next      = avm_wr_reg;
    avm_addr_next    = avm_addr_reg;
    avm_wdata_next   = avm_wdata_reg;
    avm_byte_en_next = avm_byte_en_reg;
    data_out_next    = data_out_reg;
    err_next         = err_clr ? 1'b0 : err_reg;
    if (timeout_hit) err_next = 1'b1;

    if (m_state_next == M_WRITE && m_state_reg != M_WRITE) begin
      avm_wr_next = 1'b1;
      {avm_addr_next, avm_wdata_next, avm_byte_en_next} = head_entry;
      tcnt_clr = 1'b1;
    end
    if (m_state_next == M_READ && m_state_reg != M_READ) begin
      avm_rd_next   = 1'b1;
      avm_addr_next = rd_addr_sel;
      tcnt_clr      = 1'b1;
    end

    case (m_state_reg)
      M_WRITE: begin
        if (wr_done) begin
          pop         = 1'b1;
          avm_wr_next = 1'b0;
        end
      end
      M_READ: begin
        if (timeout_hit) begin
          avm_rd_next   = 1'b0;
          data_out_next = '1;
          read_done     = 1'b1;
        end else if (!avm_wait) begin
          avm_rd_next = 1'b0;
        end
      end
      M_READ_DATA: begin
        if (timeout_hit) begin
          data_out_next = '1;
          read_done     = 1'b1;
        end else if (avm_rdvalid) begin
          data_out_next = avm_rdata;
          read_done     = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign data_out    = data_out_reg;
  assign wait_out    = wait_reg;
  assign err         = err_reg;
  assign wfifo_level = count_reg;
  assign avm_addr    = avm_addr_reg;
  assign avm_rd      = avm_rd_reg;
  assign avm_wr      = avm_wr_reg;
  assign avm_wdata   = avm_wdata_reg;
  assign avm_byte_en = avm_byte_en_reg;

endmodule

// File: tb/tb_fsmc_avm_bridge.sv
// Directed bench for fsmc_avm_bridge: posted writes, FIFO full stall,
// read-after-write ordering, timeout, simultaneous strobes, async reset.
module tb_fsmc_avm_bridge;

  logic        clk = 1'b0;
  logic        avm_reset_n;
  logic [31:0] addr;
  logic        ncs, rd_start, wr_start, err_clr;
  logic [1:0]  byte_en;
  logic [15:0] data_in, avm_rdata;
  logic        avm_rdvalid, avm_wait;

  logic [15:0] data_out, avm_wdata, to_data_out, to_avm_wdata;
  logic        wait_out, err, avm_rd, avm_wr;
  logic        to_wait_out, to_err, to_avm_rd, to_avm_wr;
  logic [2:0]  wfifo_level, to_wfifo_level;
  logic [31:0] avm_addr, to_avm_addr;
  logic [1:0]  avm_byte_en, to_avm_byte_en;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fsmc_avm_bridge #(.AW(32), .DW(16), .WFIFO_DEPTH(4), .TIMEOUT(64)) dut (
    .avm_clk(clk), .avm_reset_n(avm_reset_n), .addr(addr), .ncs(ncs),
    .rd_start(rd_start), .wr_start(wr_start), .byte_en(byte_en), .data_in(data_in),
    .data_out(data_out), .wait_out(wait_out), .err(err), .err_clr(err_clr),
    .wfifo_level(wfifo_level), .avm_addr(avm_addr), .avm_rd(avm_rd), .avm_wr(avm_wr),
    .avm_wdata(avm_wdata), .avm_byte_en(avm_byte_en), .avm_rdata(avm_rdata),
    .avm_rdvalid(avm_rdvalid), .avm_wait(avm_wait)
  );

  // Short-timeout instance, only observed in the timeout scenario.
  fsmc_avm_bridge #(.AW(32), .DW(16), .WFIFO_DEPTH(4), .TIMEOUT(8)) dut_to (
    .avm_clk(clk), .avm_reset_n(avm_reset_n), .addr(addr), .ncs(ncs),
    .rd_start(rd_start), .wr_start(wr_start), .byte_en(byte_en), .data_in(data_in),
    .data_out(to_data_out), .wait_out(to_wait_out), .err(to_err), .err_clr(err_clr),
    .wfifo_level(to_wfifo_level), .avm_addr(to_avm_addr), .avm_rd(to_avm_rd),
    .avm_wr(to_avm_wr), .avm_wdata(to_avm_wdata), .avm_byte_en(to_avm_byte_en),
    .avm_rdata(avm_rdata), .avm_rdvalid(avm_rdvalid), .avm_wait(avm_wait)
  );

  // Bus monitor on the main instance.
  logic        mon_clr;
  logic [31:0] wq_addr [0:15];
  logic [15:0] wq_data [0:15];
  logic [1:0]  wq_be   [0:15];
  int wq_n, rd_cycles, act_cycles, wait_low, max_level;

  always @(negedge clk) begin
    if (mon_clr) begin
      wq_n = 0; rd_cycles = 0; act_cycles = 0; wait_low = 0; max_level = 0;
    end else begin
      if (avm_wr && !avm_wait && wq_n < 16) begin
        wq_addr[wq_n] = avm_addr;
        wq_data[wq_n] = avm_wdata;
        wq_be[wq_n]   = avm_byte_en;
        wq_n++;
      end
      if (avm_rd) rd_cycles++;
      if (avm_rd || avm_wr) act_cycles++;
      if (!wait_out) wait_low++;
      if (int'(wfifo_level) > max_level) max_level = int'(wfifo_level);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok %s = 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    avm_reset_n = 1'b0; mon_clr = 1'b1;
    ncs = 1'b1; rd_start = 1'b0; wr_start = 1'b0; err_clr = 1'b0;
    addr = '0; data_in = '0; byte_en = '0;
    avm_wait = 1'b0; avm_rdvalid = 1'b0; avm_rdata = '0;
    tick(); tick();
    avm_reset_n = 1'b1; mon_clr = 1'b0;
    tick();
  endtask

  // Host write: strobe high for one cycle, low for one cycle.
  task automatic hw(input logic [31:0] a, input logic [15:0] d, input logic [1:0] b);
    addr = a; data_in = d; byte_en = b; ncs = 1'b0; wr_start = 1'b1;
    tick();
    wr_start = 1'b0;
    tick();
  endtask

  function automatic logic [31:0] wa(input int i);
    return 32'h1000_0000 + 32'(i * 16);
  endfunction
  function automatic logic [15:0] wd(input int i);
    return 16'hA000 + 16'(i * 257);
  endfunction
  function automatic logic [1:0] wb(input int i);
    return 2'(i % 3 + 1);
  endfunction

  initial begin
    do_reset();
    check("rst_data_out", data_out, 0);
    check("rst_wait_out", wait_out, 1);
    check("rst_err", err, 0);
    check("rst_level", wfifo_level, 0);
    check("rst_avm_rd_wr", {avm_rd, avm_wr}, 0);

    // ---- posted writes, ncs gating
    ncs = 1'b1; addr = 32'hDEAD_0000; wr_start = 1'b1;
    tick(); wr_start = 1'b0; tick(); tick();
    check("ncs_high_ignored", wfifo_level, 0);
    addr = wa(0); data_in = wd(0); byte_en = wb(0); ncs = 1'b0; wr_start = 1'b1;
    tick();
    check("w0_level_c1", wfifo_level, 1);
    check("w0_avm_wr_c1", avm_wr, 0);
    wr_start = 1'b0;
    tick();
    check("w0_avm_wr_c2", avm_wr, 1);
    check("w0_avm_addr_c2", avm_addr, wa(0));
    for (int i = 1; i < 4; i++) hw(wa(i), wd(i), wb(i));
    repeat (8) tick();
    check("posted_count", wq_n, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("posted_addr%0d", i), wq_addr[i], wa(i));
      check($sformatf("posted_data%0d", i), wq_data[i], wd(i));
      check($sformatf("posted_be%0d", i), wq_be[i], wb(i));
    end
    check("posted_no_stall", wait_low, 0);

    // ---- FIFO full with avm_wait held
    do_reset();
    avm_wait = 1'b1;
    for (int i = 0; i < 4; i++) hw(wa(i), wd(i), wb(i));
    check("full_level_c8", wfifo_level, 4);
    check("full_wait_c8", wait_out, 1);
    addr = wa(4); data_in = wd(4); byte_en = wb(4); wr_start = 1'b1;
    tick();
    check("full_wait_c9", wait_out, 0);
    check("full_stuck_addr", avm_addr, wa(0));
    wr_start = 1'b0;
    tick();
    check("full_wait_c10", wait_out, 0);
    avm_wait = 1'b0;
    tick();
    check("full_release_c11", wait_out, 1);
    check("full_level_c11", wfifo_level, 4);
    repeat (20) tick();
    check("full_count", wq_n, 5);
    check("full_addr4", wq_addr[4], wa(4));
    check("full_data4", wq_data[4], wd(4));
    check("full_max_level", max_level, 4);

    // ---- read after writes
    do_reset();
    avm_wait = 1'b1;
    hw(wa(0), wd(0), wb(0));
    hw(wa(1), wd(1), wb(1));
    addr = 32'h0000_0100; rd_start = 1'b1;
    tick();
    check("raw_wait_c5", wait_out, 0);
    check("raw_rd_c5", avm_rd, 0);
    rd_start = 1'b0;
    tick(); tick();
    check("raw_w1_stuck_c7", avm_addr, wa(0));
    avm_wait = 1'b0;
    tick();
    check("raw_c8_idle", {avm_rd, avm_wr}, 0);
    tick();
    check("raw_c9_wr", {avm_rd, avm_wr}, 1);
    check("raw_c9_addr", avm_addr, wa(1));
    tick();
    check("raw_c10_rd", {avm_rd, avm_wr}, 2);
    check("raw_c10_addr", avm_addr, 32'h100);
    tick();
    check("raw_c11_rd_low", avm_rd, 0);
    check("raw_c11_wait", wait_out, 0);
    avm_rdata = 16'h5A5A; avm_rdvalid = 1'b1;
    tick();
    avm_rdvalid = 1'b0;
    check("raw_data_out", data_out, 16'h5A5A);
    check("raw_wait_release", wait_out, 1);
    check("raw_write_count", wq_n, 2);

    // ---- timeout on the TIMEOUT=8 instance
    do_reset();
    addr = 32'h0000_0200; ncs = 1'b0; rd_start = 1'b1;
    tick();
    check("to_rd_c1", to_avm_rd, 1);
    rd_start = 1'b0;
    repeat (7) tick();
    check("to_err_c8", to_err, 0);
    check("to_wait_c8", to_wait_out, 0);
    tick();
    check("to_err_c9", to_err, 1);
    check("to_data_c9", to_data_out, 16'hFFFF);
    check("to_wait_c9", to_wait_out, 1);
    tick(); tick();
    check("to_err_sticky", to_err, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("to_err_cleared", to_err, 0);

    // ---- simultaneous strobes
    do_reset();
    addr = 32'h0000_0300; data_in = 16'h1234; byte_en = 2'b11; ncs = 1'b0;
    rd_start = 1'b1; wr_start = 1'b1;
    tick();
    check("sim_level_c1", wfifo_level, 1);
    check("sim_wait_c1", wait_out, 1);
    rd_start = 1'b0; wr_start = 1'b0;
    tick();
    check("sim_c2_wr", {avm_rd, avm_wr}, 1);
    repeat (6) tick();
    check("sim_no_read", rd_cycles, 0);
    check("sim_one_write", wq_n, 1);
    check("sim_write_data", wq_data[0], 16'h1234);

    // ---- asynchronous reset mid-operation
    do_reset();
    avm_wait = 1'b1;
    hw(wa(0), wd(0), wb(0));
    hw(wa(1), wd(1), wb(1));
    addr = 32'h0000_0400; rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    tick();
    check("mid_pre_wait", wait_out, 0);
    check("mid_pre_level", wfifo_level, 2);
    #2;
    avm_reset_n = 1'b0;
    #1;
    check("mid_rst_avm", {avm_rd, avm_wr}, 0);
    check("mid_rst_addr", avm_addr, 0);
    check("mid_rst_wdata_be", {avm_wdata, avm_byte_en}, 0);
    check("mid_rst_data_out", data_out, 0);
    check("mid_rst_wait", wait_out, 1);
    check("mid_rst_err", err, 0);
    check("mid_rst_level", wfifo_level, 0);
    mon_clr = 1'b1;
    tick(); tick();
    avm_wait = 1'b0; avm_reset_n = 1'b1; mon_clr = 1'b0;
    repeat (10) tick();
    check("mid_post_quiet", act_cycles, 0);
    check("mid_post_level", wfifo_level, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
